// File: rtl/uart_frame_tx.sv
// uart_frame_tx: builds and sends the "P<amp4><freq6>\r\n" ASCII frame through a byte UART TX core.
// Define UART_FRAME_TX_CKSUM_EN to insert an XOR checksum byte before CR.
module uart_frame_tx #(
  parameter int AMP_W    = 14,
  parameter int FREQ_W   = 20,
  parameter int CONV_CYC = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              send,
  input  logic [AMP_W-1:0]  amp_in,
  input  logic [FREQ_W-1:0] freq_in,
  input  logic              tx_busy,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  output logic              busy,
  output logic              done
);
`ifdef UART_FRAME_TX_CKSUM_EN
  localparam int NB = 14;
`else
  localparam int NB = 13;
`endif
  localparam logic [3:0] LAST = 4'(NB - 1);
  localparam int CW = $clog2(CONV_CYC + 1);
  typedef enum logic [2:0] {IDLE, CONV, LOAD, START, WAIT_ACK, WAIT_DONE, FIN} state_t;
  state_t              state_q, state_d;
  logic [CONV_CYC-1:0] amp_sh_q, amp_sh_d, freq_sh_q, freq_sh_d;
  logic [15:0]         amp_bcd_q, amp_bcd_d, amp_a;
  logic [23:0]         freq_bcd_q, freq_bcd_d, freq_a;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [3:0]          idx_q, idx_d, sel;
  logic [7:0]          tx_data_d, cur_byte;
  logic                tx_start_d, busy_d, done_d;
  logic [AMP_W-1:0]    amp_sat;
  logic [FREQ_W-1:0]   freq_sat;
  logic [7:0]          frame [NB];

  function automatic logic [3:0] adj(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  assign amp_sat  = (32'(amp_in) > 32'd9999) ? AMP_W'(9999) : amp_in;
  assign freq_sat = (32'(freq_in) > 32'd999999) ? FREQ_W'(999999) : freq_in;

  always_comb begin
    for (int i = 0; i < 4; i++) amp_a[4*i +: 4] = adj(amp_bcd_q[4*i +: 4]);
    for (int i = 0; i < 6; i++) freq_a[4*i +: 4] = adj(freq_bcd_q[4*i +: 4]);
  end

`ifdef UART_FRAME_TX_CKSUM_EN
  logic [3:0] ck;
  always_comb begin
    ck = 4'h0;
    for (int i = 0; i < 4; i++) ck = ck ^ amp_bcd_q[4*i +: 4];
    for (int i = 0; i < 6; i++) ck = ck ^ freq_bcd_q[4*i +: 4];
  end
`endif

  always_comb begin
    frame[0] = 8'h50;
    for (int i = 0; i < 4; i++) frame[1+i] = {4'h3, amp_bcd_q[15-4*i -: 4]};
    for (int i = 0; i < 6; i++) frame[5+i] = {4'h3, freq_bcd_q[23-4*i -: 4]};
`ifdef UART_FRAME_TX_CKSUM_EN
    // ten 0x3 high nibbles cancel, leaving the XOR of the BCD digits
    frame[11] = {4'h0, ck};
`endif
    frame[NB-2] = 8'h0D;
    frame[NB-1] = 8'h0A;
  end

  assign sel      = (state_q == WAIT_DONE && idx_q != LAST) ? idx_q + 4'd1 : idx_q;
  assign cur_byte = frame[sel];

  always_comb begin
    state_d    = state_q;
    amp_sh_d   = amp_sh_q;
    freq_sh_d  = freq_sh_q;
    amp_bcd_d  = amp_bcd_q;
    freq_bcd_d = freq_bcd_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data;
    tx_start_d = 1'b0;
    busy_d     = busy;
    done_d     = 1'b0;
    case (state_q)
      IDLE: if (send) begin
        amp_sh_d   = CONV_CYC'(amp_sat);
        freq_sh_d  = CONV_CYC'(freq_sat);
        amp_bcd_d  = '0;
        freq_bcd_d = '0;
        cnt_d      = '0;
        idx_d      = '0;
        busy_d     = 1'b1;
        state_d    = CONV;
      end
      CONV: begin
        amp_bcd_d  = 16'({amp_a, amp_sh_q[CONV_CYC-1]});
        freq_bcd_d = 24'({freq_a, freq_sh_q[CONV_CYC-1]});
        amp_sh_d   = amp_sh_q << 1;
        freq_sh_d  = freq_sh_q << 1;
        cnt_d      = cnt_q + CW'(1);
        if (cnt_q == CW'(CONV_CYC - 1)) state_d = LOAD;
      end
      LOAD: begin
        idx_d      = '0;
        tx_data_d  = cur_byte;
        tx_start_d = !tx_busy;
        state_d    = START;
      end
      // a registered strobe already high means the byte was launched this cycle
      START: if (tx_start) state_d = WAIT_ACK;
      else if (!tx_busy) begin
        tx_start_d = 1'b1;
        tx_data_d  = cur_byte;
      end
      WAIT_ACK: if (tx_busy) state_d = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) begin
        if (idx_q == LAST) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = FIN;
        end else begin
          idx_d      = idx_q + 4'd1;
          tx_data_d  = cur_byte;
          tx_start_d = 1'b1;
          state_d    = START;
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      amp_sh_q   <= '0;
      freq_sh_q  <= '0;
      amp_bcd_q  <= '0;
      freq_bcd_q <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      tx_data    <= 8'h00;
      tx_start   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      amp_sh_q   <= amp_sh_d;
      freq_sh_q  <= freq_sh_d;
      amp_bcd_q  <= amp_bcd_d;
      freq_bcd_q <= freq_bcd_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      tx_data    <= tx_data_d;
      tx_start   <= tx_start_d;
      busy       <= busy_d;
      done       <= done_d;
    end
endmodule

// File: tb/tb_uart_frame_tx.sv
// tb_uart_frame_tx: randomized scoreboard bench for uart_frame_tx with a behavioural UART TX core.
module tb_uart_frame_tx;
`ifdef UART_FRAME_TX_CKSUM_EN
  localparam int NB = 14;
`else
  localparam int NB = 13;
`endif
  logic        clk = 1'b0, rst_n = 1'b0, send = 1'b0, tx_busy = 1'b0;
  logic [13:0] amp_in = '0;
  logic [19:0] freq_in = '0;
  logic [7:0]  tx_data;
  logic        tx_start, busy, done;
  int          vectors = 0, miscompares = 0;
  logic [7:0]  exp_q[$];
  int          cyc = 0, starts = 0, dones = 0, nbytes = 0, exp_first = -1, busy_len = 10;
  bit          hold_busy = 0, mon_en = 0, holding = 0, prev_busy = 0;
  logic [7:0]  held = '0;

  uart_frame_tx dut (
    .clk(clk), .rst_n(rst_n), .send(send), .amp_in(amp_in), .freq_in(freq_in),
    .tx_busy(tx_busy), .tx_data(tx_data), .tx_start(tx_start), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference: saturate, then peel decimal digits with division
  task automatic push_frame(input int a, input int f);
    int sa = (a > 9999) ? 9999 : a;
    int sf = (f > 999999) ? 999999 : f;
    int p;
    logic [7:0] b, ck;
    ck = 8'h00;
    exp_q.push_back(8'h50);
    p = 1000;
    for (int k = 0; k < 4; k++) begin
      b = 8'(48 + (sa / p) % 10);
      exp_q.push_back(b); ck ^= b; p /= 10;
    end
    p = 100000;
    for (int k = 0; k < 6; k++) begin
      b = 8'(48 + (sf / p) % 10);
      exp_q.push_back(b); ck ^= b; p /= 10;
    end
`ifdef UART_FRAME_TX_CKSUM_EN
    exp_q.push_back(ck);
`endif
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // UART core: busy for busy_len cycles after each strobe, or forced by hold_busy
  initial begin : uart
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk); #2;
      if (tx_start) cnt = busy_len;
      tx_busy = hold_busy || cnt > 0;
      if (cnt > 0) cnt--;
    end
  end

  always @(posedge clk) begin
    #1;
    if (mon_en && rst_n) begin
      if (tx_start) begin
        chk("no_start_while_busy", 32'(tx_busy), 0);
        if (nbytes == 0 && exp_first >= 0) begin
          chk("first_start_cycle", cyc, exp_first);
          exp_first = -1;
        end
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_byte: got %02h expected none", tx_data);
        end else chk("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
        held = tx_data; holding = 1; nbytes++; starts++;
      end else if (holding) chk("tx_data_stable", 32'(tx_data), 32'(held));
      if (done) begin
        chk("busy_low_with_done", 32'(busy), 0);
        chk("bytes_per_frame", nbytes, NB);
        nbytes = 0; holding = 0; dones++;
      end else if (prev_busy) chk("busy_continuous", 32'(busy), 1);
      prev_busy = busy;
    end
  end

  task automatic wait_for(input bit on_done, input int target, input int budget);
    int n = 0;
    while ((on_done ? dones : starts) < target && n < budget) begin
      @(negedge clk); n++;
    end
    chk(on_done ? "done_timeout" : "start_timeout", 32'((on_done ? dones : starts) >= target), 1);
  endtask

  task automatic start_frame(input int a, input int f, input bit timed);
    @(negedge clk);
    amp_in = 14'(a); freq_in = 20'(f); send = 1'b1;
    push_frame(a, f);
    if (timed) exp_first = cyc + 22;
    @(negedge clk);
    send = 1'b0;
  endtask

  initial begin
    int s0, a, f;
    repeat (2) @(negedge clk);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst_n = 1'b1; mon_en = 1;
    start_frame(20, 100, 1);
    wait_for(1, 1, 400);
    start_frame(12000, 1048575, 1);
    wait_for(1, 2, 400);
    busy_len = 50; hold_busy = 1;
    start_frame(4321, 98765, 0);
    repeat (40) @(negedge clk);
    hold_busy = 0;
    wait_for(1, 3, 1500);
    busy_len = 10;
    s0 = starts;
    start_frame(777, 123456, 1);
    wait_for(0, s0 + 5, 300);
    @(negedge clk); send = 1'b1; amp_in = 14'd9; freq_in = 20'd5;
    @(negedge clk); send = 1'b0;
    wait_for(1, 4, 400);
    repeat (60) @(negedge clk);
    chk("no_second_frame", starts, s0 + NB);
    chk("idle_after_frame", 32'(busy), 0);
    @(negedge clk);
    amp_in = 14'd305; freq_in = 20'd60007; send = 1'b1;
    push_frame(305, 60007); push_frame(305, 60007);
    wait_for(1, 5, 400);
    @(negedge clk); @(negedge clk);
    chk("back_to_back_busy", 32'(busy), 1);
    send = 1'b0;
    wait_for(1, 6, 400);
    for (int i = 0; i < 6; i++) begin
      busy_len = $urandom_range(2, 12);
      a = $urandom_range(0, 16383);
      f = $urandom_range(0, 1048575);
      start_frame(a, f, 1);
      wait_for(1, 7 + i, 600);
    end
    busy_len = 10;
    s0 = starts;
    start_frame(5678, 424242, 1);
    wait_for(0, s0 + 8, 300);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0; mon_en = 0;
    #1;
    chk("midrst_tx_data", 32'(tx_data), 0);
    chk("midrst_tx_start", 32'(tx_start), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    exp_q.delete(); holding = 0; nbytes = 0; prev_busy = 0; exp_first = -1;
    repeat (15) @(negedge clk);
    rst_n = 1'b1; mon_en = 1;
    start_frame(0, 0, 1);
    wait_for(1, 13, 400);
    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
